lsu_mem_master: RTL

LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

---
 rtl/lsu_mem_master_if.sv | 32 +++
 rtl/lsu_mem_master.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master_if.sv
// Load/store unit bus bundle: core request/response channel plus the
// data-memory port. The "master" modport is the LSU side, "slave" is the
// core/memory environment side.
interface lsu_mem_master_if;
   logic        i_req_valid;
   logic        o_req_ready;
   logic        i_req_we;
   logic [2:0]  i_req_funct3;
   logic [31:0] i_req_addr;
   logic [31:0] i_req_wdata;
   logic        o_rsp_valid;
   logic [31:0] o_rsp_rdata;
   logic        o_rsp_err;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_w_data;
   logic [2:0]  o_mem_fmt;
   logic        o_mem_r_en;
   logic        o_mem_w_en;
   logic [31:0] i_mem_r_data;

   modport master (
      input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata, i_mem_r_data,
      output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
             o_mem_addr, o_mem_w_data, o_mem_fmt, o_mem_r_en, o_mem_w_en
   );

   modport slave (
      output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata, i_mem_r_data,
      input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
             o_mem_addr, o_mem_w_data, o_mem_fmt, o_mem_r_en, o_mem_w_en
   );
endinterface

// File: rtl/lsu_mem_master.sv
// RV32I load/store memory master. Accepts one core request at a time,
// performs an aligned access in one cycle or splits a misaligned half/word
// into byte accesses, then returns a one-cycle response with extended data.
module lsu_mem_master #(
   parameter int unsigned SPLIT_MISALIGNED = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   lsu_mem_master_if.master bus
);

   localparam bit SPLIT_EN = (SPLIT_MISALIGNED != 0);

   typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

   state_t      state_q;
   logic [1:0]  k_q;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] result_q;
   logic        req_ready_q;
   logic        rsp_valid_q;
   logic [31:0] rsp_rdata_q;
   logic        rsp_err_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_w_data_q;
   logic [2:0]  mem_fmt_q;
   logic        mem_r_en_q;
   logic        mem_w_en_q;

   logic        req_fire_d;
   logic        req_bad_d;
   logic        req_misal_d;
   logic [31:0] merged_d;
   logic [31:0] raw_d;
   logic [31:0] ext_d;
   logic [1:0]  k_d;
   logic [1:0]  last_k_d;
   logic [31:0] split_addr_d;
   logic [7:0]  split_wbyte_d;

   assign bus.o_req_ready  = req_ready_q;
   assign bus.o_rsp_valid  = rsp_valid_q;
   assign bus.o_rsp_rdata  = rsp_rdata_q;
   assign bus.o_rsp_err    = rsp_err_q;
   assign bus.o_mem_addr   = mem_addr_q;
   assign bus.o_mem_w_data = mem_w_data_q;
   assign bus.o_mem_fmt    = mem_fmt_q;
   assign bus.o_mem_r_en   = mem_r_en_q;
   assign bus.o_mem_w_en   = mem_w_en_q;

   // Classify the incoming request: illegal width code or misaligned address.
   always_comb begin
      req_fire_d = bus.i_req_valid && req_ready_q;
      if (bus.i_req_we) begin
         req_bad_d = bus.i_req_funct3[2] || (bus.i_req_funct3[1:0] == 2'b11);
      end else begin
         req_bad_d = (bus.i_req_funct3 == 3'b011) || (bus.i_req_funct3[2:1] == 2'b11);
      end
      case (bus.i_req_funct3[1:0])
         2'b01:   req_misal_d = bus.i_req_addr[0];
         2'b10:   req_misal_d = |bus.i_req_addr[1:0];
         default: req_misal_d = 1'b0;
      endcase
   end

   // Byte-merge for split loads, load extension, and next split beat address/data.
   // Sign-extended memory data is re-masked here so BU/HU come out zero-extended.
   always_comb begin
      merged_d = result_q;
      case (k_q)
         2'd0: merged_d[7:0]   = bus.i_mem_r_data[7:0];
         2'd1: merged_d[15:8]  = bus.i_mem_r_data[7:0];
         2'd2: merged_d[23:16] = bus.i_mem_r_data[7:0];
         2'd3: merged_d[31:24] = bus.i_mem_r_data[7:0];
      endcase
      raw_d = (state_q == SPLIT) ? merged_d : bus.i_mem_r_data;
      case (funct3_q)
         3'b000:  ext_d = {{24{raw_d[7]}}, raw_d[7:0]};
         3'b001:  ext_d = {{16{raw_d[15]}}, raw_d[15:0]};
         3'b100:  ext_d = {24'b0, raw_d[7:0]};
         3'b101:  ext_d = {16'b0, raw_d[15:0]};
         default: ext_d = raw_d;
      endcase
      k_d          = k_q + 2'd1;
      last_k_d     = funct3_q[1] ? 2'd3 : 2'd1;
      split_addr_d = addr_q + {30'b0, k_d};
      case (k_d)
         2'd0: split_wbyte_d = wdata_q[7:0];
         2'd1: split_wbyte_d = wdata_q[15:8];
         2'd2: split_wbyte_d = wdata_q[23:16];
         2'd3: split_wbyte_d = wdata_q[31:24];
      endcase
   end

   // Control FSM with registered memory-port and response outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= IDLE;
         k_q          <= '0;
         we_q         <= 1'b0;
         funct3_q     <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         result_q     <= '0;
         req_ready_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
         mem_addr_q   <= '0;
         mem_w_data_q <= '0;
         mem_fmt_q    <= '0;
         mem_r_en_q   <= 1'b0;
         mem_w_en_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_fire_d) begin
                  req_ready_q <= 1'b0;
                  we_q        <= bus.i_req_we;
                  funct3_q    <= bus.i_req_funct3;
                  addr_q      <= bus.i_req_addr;
                  wdata_q     <= bus.i_req_wdata;
                  result_q    <= '0;
                  k_q         <= '0;
                  if (req_bad_d || (req_misal_d && !SPLIT_EN)) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                  end else begin
                     state_q    <= req_misal_d ? SPLIT : ACCESS;
                     mem_addr_q <= bus.i_req_addr;
                     mem_r_en_q <= !bus.i_req_we;
                     mem_w_en_q <= bus.i_req_we;
                     if (req_misal_d) begin
                        mem_fmt_q    <= 3'b000;
                        mem_w_data_q <= {24'b0, bus.i_req_wdata[7:0]};
                     end else begin
                        mem_fmt_q    <= {1'b0, bus.i_req_funct3[1:0]};
                        mem_w_data_q <= bus.i_req_wdata;
                     end
                  end
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            ACCESS: begin
               state_q      <= RESP;
               mem_addr_q   <= '0;
               mem_w_data_q <= '0;
               mem_fmt_q    <= '0;
               mem_r_en_q   <= 1'b0;
               mem_w_en_q   <= 1'b0;
               rsp_valid_q  <= 1'b1;
               rsp_err_q    <= 1'b0;
               rsp_rdata_q  <= we_q ? '0 : ext_d;
            end
            SPLIT: begin
               if (!we_q) begin
                  result_q <= merged_d;
               end
               if (k_q == last_k_d) begin
                  state_q      <= RESP;
                  k_q          <= '0;
                  mem_addr_q   <= '0;
                  mem_w_data_q <= '0;
                  mem_fmt_q    <= '0;
                  mem_r_en_q   <= 1'b0;
                  mem_w_en_q   <= 1'b0;
                  rsp_valid_q  <= 1'b1;
                  rsp_err_q    <= 1'b0;
                  rsp_rdata_q  <= we_q ? '0 : ext_d;
               end else begin
                  k_q          <= k_d;
                  mem_addr_q   <= split_addr_d;
                  mem_w_data_q <= {24'b0, split_wbyte_d};
               end
            end
            RESP: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
